// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: store/load mode selects,
// access sizes, FSM states and the alignment rule.
package mau_pkg;

   typedef enum logic [1:0] {
      DW_WORD = 2'b00,
      DW_BYTE = 2'b01,
      DW_HALF = 2'b11
   } dw_sel_e;

   typedef enum logic [2:0] {
      DR_WORD  = 3'b000,
      DR_BYTE  = 3'b001,
      DR_HALF  = 3'b010,
      DR_BYTEU = 3'b011,
      DR_HALFU = 3'b100
   } dr_sel_e;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } acc_size_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP,
      S_ERR
   } mau_state_e;

   // Unlisted select codes (DataWSel 10, DataRSel 101..111) fall back to word.
   function automatic acc_size_e access_size(input logic       we,
                                             input logic [1:0] wsel,
                                             input logic [2:0] rsel);
      acc_size_e sz;
      sz = SZ_WORD;
      if (we) begin
         if (wsel == DW_BYTE)      sz = SZ_BYTE;
         else if (wsel == DW_HALF) sz = SZ_HALF;
      end else begin
         if (rsel == DR_BYTE || rsel == DR_BYTEU)      sz = SZ_BYTE;
         else if (rsel == DR_HALF || rsel == DR_HALFU) sz = SZ_HALF;
      end
      return sz;
   endfunction

   function automatic logic is_misaligned(input logic       we,
                                          input logic [1:0] wsel,
                                          input logic [2:0] rsel,
                                          input logic [1:0] lo);
      logic bad;
      bad = 1'b0;
      case (access_size(we, wsel, rsel))
         SZ_HALF: bad = lo[0];
         SZ_WORD: bad = (lo != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mau_if.sv
// Word-wide req/ack data memory bus. The access unit is the master,
// data memory is the slave.
interface mau_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mau_lane_align.sv
// Combinational byte-lane handling: store byte enables and lane
// replication, load lane extraction with sign/zero extension.
module mau_lane_align
   import mau_pkg::*;
(
   input  logic        st_we,
   input  logic [1:0]  st_wsel,
   input  logic [1:0]  st_lo,
   input  logic [31:0] st_data,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata,
   input  logic [2:0]  ld_rsel,
   input  logic [1:0]  ld_lo,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Store placement: narrow data is replicated so every enabled lane carries it.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = st_data;
      if (st_we) begin
         case (st_wsel)
            DW_BYTE: begin
               st_be    = 4'b0001 << st_lo;
               st_wdata = {4{st_data[7:0]}};
            end
            DW_HALF: begin
               st_be    = 4'b0011 << st_lo;
               st_wdata = {2{st_data[15:0]}};
            end
            default: begin
               st_be    = 4'b1111;
               st_wdata = st_data;
            end
         endcase
      end
   end

   // Load extraction: pick the addressed lane and extend to 32 bits.
   always_comb begin
      ld_byte = 8'(ld_word >> {ld_lo, 3'b000});
      ld_half = 16'(ld_word >> {ld_lo[1], 4'b0000});
      case (ld_rsel)
         DR_BYTE:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         DR_BYTEU: ld_data = {24'h000000, ld_byte};
         DR_HALF:  ld_data = {{16{ld_half[15]}}, ld_half};
         DR_HALFU: ld_data = {16'h0000, ld_half};
         default:  ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Sequential load/store engine between execute and data memory.
// Optional REQ timeout is enabled by defining MAU_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | waiting for start; also the done cycle of an error completion
// S_REQ  | mem_req held, waiting for mem_ack (or timeout)
// S_RESP | done pulse of a normal completion
// S_ERR  | misaligned or timed-out access, raises done + error next cycle
module mem_access_unit
   import mau_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        MemRW,
   input  logic [1:0]  DataWSel,
   input  logic [2:0]  DataRSel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata_out,
   output logic        err_align,
   output logic        err_timeout,
   mau_if.master       bus
);

   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("mem_access_unit: TIMEOUT_CYC must be within 1..255");
   end

   mau_state_e  state;
   logic        op_we;
   logic [2:0]  op_rsel;
   logic [1:0]  op_lo;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

`ifdef MAU_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
   logic [7:0] to_cnt;
   logic       to_flag;
   logic       err_to_q;
   assign err_timeout = err_to_q;
`else
   assign err_timeout = 1'b0;
`endif

   // Store side sees the live request so placement can be registered at accept;
   // load side uses the captured mode/offset against the bus read word.
   mau_lane_align u_lane_align (
      .st_we    (MemRW),
      .st_wsel  (DataWSel),
      .st_lo    (addr[1:0]),
      .st_data  (wdata),
      .st_be    (st_be),
      .st_wdata (st_wdata),
      .ld_rsel  (op_rsel),
      .ld_lo    (op_lo),
      .ld_word  (bus.mem_rdata),
      .ld_data  (ld_data)
   );

   // Main FSM with all outputs registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         err_align     <= 1'b0;
         rdata_out     <= 32'h0;
         op_we         <= 1'b0;
         op_rsel       <= 3'b000;
         op_lo         <= 2'b00;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= 32'h0;
         bus.mem_be    <= 4'h0;
         bus.mem_wdata <= 32'h0;
`ifdef MAU_TIMEOUT_EN
         to_cnt        <= 8'h00;
         to_flag       <= 1'b0;
         err_to_q      <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done      <= 1'b0;
               err_align <= 1'b0;
`ifdef MAU_TIMEOUT_EN
               err_to_q  <= 1'b0;
`endif
               // busy still high here means this is the done cycle of an error
               // completion; a new start is only taken once that has passed.
               if (busy) begin
                  busy <= 1'b0;
               end else if (start) begin
                  busy         <= 1'b1;
                  op_we        <= MemRW;
                  op_rsel      <= DataRSel;
                  op_lo        <= addr[1:0];
                  bus.mem_addr <= {addr[31:2], 2'b00};
`ifdef MAU_TIMEOUT_EN
                  to_flag      <= 1'b0;
                  to_cnt       <= 8'h00;
`endif
                  if (is_misaligned(MemRW, DataWSel, DataRSel, addr[1:0])) begin
                     state <= S_ERR;
                  end else begin
                     state         <= S_REQ;
                     bus.mem_req   <= 1'b1;
                     bus.mem_we    <= MemRW;
                     bus.mem_be    <= st_be;
                     bus.mem_wdata <= st_wdata;
                  end
               end
            end
            S_REQ: begin
               if (bus.mem_ack) begin
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  done        <= 1'b1;
                  if (!op_we) rdata_out <= ld_data;
                  state       <= S_RESP;
               end
`ifdef MAU_TIMEOUT_EN
               else if (to_cnt == TO_LAST) begin
                  bus.mem_req <= 1'b0;
                  bus.mem_we  <= 1'b0;
                  to_flag     <= 1'b1;
                  state       <= S_ERR;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
`endif
            end
            S_RESP: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_ERR: begin
               done      <= 1'b1;
`ifdef MAU_TIMEOUT_EN
               err_align <= ~to_flag;
               err_to_q  <= to_flag;
`else
               err_align <= 1'b1;
`endif
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_mem_access_unit;

`ifdef MAU_TIMEOUT_EN
   localparam int TO_CYC = 4;
`else
   localparam int TO_CYC = 255;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        MemRW = 1'b0;
   logic [1:0]  DataWSel = 2'b00;
   logic [2:0]  DataRSel = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        busy, done, err_align, err_timeout;
   logic [31:0] rdata_out;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_rdata = 32'h0;

   mau_if bus ();

   mem_access_unit #(.TIMEOUT_CYC(TO_CYC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .MemRW       (MemRW),
      .DataWSel    (DataWSel),
      .DataRSel    (DataRSel),
      .addr        (addr),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .rdata_out   (rdata_out),
      .err_align   (err_align),
      .err_timeout (err_timeout),
      .bus         (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: access size in bytes from the mode selects.
   function automatic int size_bytes(input bit we, input bit [1:0] ws, input bit [2:0] rs);
      if (we) return (ws == 2'b01) ? 1 : (ws == 2'b11) ? 2 : 4;
      if (rs == 3'd1 || rs == 3'd3) return 1;
      if (rs == 3'd2 || rs == 3'd4) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] model_load(input bit [2:0] rs, input logic [31:0] a,
                                              input logic [31:0] rd);
      int sz;
      logic [31:0] v;
      sz = size_bytes(1'b0, 2'b00, rs);
      v  = rd >> (8 * (a % 4));
      if (sz == 1) begin
         v = v & 32'hFF;
         if (rs == 3'd1 && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (sz == 2) begin
         v = v & 32'hFFFF;
         if (rs == 3'd2 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   task automatic do_txn(input bit we, input bit [1:0] ws, input bit [2:0] rs,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rd, input int dly, input bit spam);
      int          sz;
      bit          mis;
      logic [3:0]  be_exp;
      logic [31:0] wd_exp;
      sz  = size_bytes(we, ws, rs);
      mis = (a % sz) != 0;
      if (!we || sz == 4) be_exp = 4'hF;
      else be_exp = 4'(((1 << sz) - 1) << (a % 4));
      if (!we || sz == 4) wd_exp = wd;
      else if (sz == 1) wd_exp = (wd & 32'hFF) * 32'h0101_0101;
      else wd_exp = (wd & 32'hFFFF) * 32'h0001_0001;

      MemRW = we; DataWSel = ws; DataRSel = rs; addr = a; wdata = wd;
      start = 1'b1;
      tick();
      start = spam;
      check("busy_c1", busy, 1);
      if (mis) begin
         check("noreq_mis_c1", bus.mem_req, 0);
         check("nodone_mis_c1", done, 0);
         tick();
         check("done_mis", done, 1);
         check("err_align_mis", err_align, 1);
         check("err_to_mis", err_timeout, 0);
         check("noreq_mis_c2", bus.mem_req, 0);
         check("rdata_keep_mis", rdata_out, exp_rdata);
         start = 1'b0;
         tick();
         check("busy_low_mis", busy, 0);
         check("done_low_mis", done, 0);
         return;
      end
      check("req_c1", bus.mem_req, 1);
      check("we", bus.mem_we, we);
      check("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
      check("mem_be", bus.mem_be, be_exp);
      check("mem_wdata", bus.mem_wdata, wd_exp);
      for (int i = 0; i < dly; i++) begin
         tick();
         check("req_hold", bus.mem_req, 1);
         check("be_hold", bus.mem_be, be_exp);
         check("nodone_wait", done, 0);
      end
      bus.mem_ack = 1'b1;
      bus.mem_rdata = rd;
      tick();
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
      if (!we) exp_rdata = model_load(rs, a, rd);
      check("done", done, 1);
      check("err_align_ok", err_align, 0);
      check("err_to_ok", err_timeout, 0);
      check("req_drop", bus.mem_req, 0);
      check("busy_done", busy, 1);
      check("rdata_out", rdata_out, exp_rdata);
      start = 1'b0;
      tick();
      check("done_low", done, 0);
      check("busy_low", busy, 0);
      check("idle_noreq", bus.mem_req, 0);
   endtask

   initial begin
      int n_done;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'h0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_req", bus.mem_req, 0);
      check("rst_we", bus.mem_we, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_be", bus.mem_be, 0);
      check("rst_wdata", bus.mem_wdata, 0);
      check("rst_rdata", rdata_out, 0);
      check("rst_errs", {err_align, err_timeout}, 0);
      rst_n = 1'b1;
      tick();

      // Directed cases from the plan.
      do_txn(1'b1, 2'b01, 3'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 1'b0);
      do_txn(1'b0, 2'b00, 3'd2, 32'h0000_2002, 32'h0, 32'h8001_1234, 1, 1'b0);
      check("half_s", rdata_out, 32'hFFFF_8001);
      do_txn(1'b0, 2'b00, 3'd4, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 1'b0);
      check("half_u", rdata_out, 32'h0000_8001);
      do_txn(1'b0, 2'b00, 3'd1, 32'h0000_2001, 32'h0, 32'h0000_8000, 2, 1'b0);
      check("byte_s", rdata_out, 32'hFFFF_FF80);
      do_txn(1'b0, 2'b00, 3'd3, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 1'b0);
      check("byte_u", rdata_out, 32'h0000_0080);
      do_txn(1'b0, 2'b00, 3'd0, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0);
      check("mis_keep", rdata_out, 32'h0000_0080);

      // Delayed ack with start hammered while busy; exactly one done.
      do_txn(1'b0, 2'b00, 3'd0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 3, 1'b1);
      n_done = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done) n_done++;
         if (bus.mem_req) n_done++;
      end
      check("no_extra_txn", n_done, 0);

      // Ack while idle is ignored.
      bus.mem_ack = 1'b1;
      bus.mem_rdata = 32'h1234_5678;
      tick();
      bus.mem_ack = 1'b0;
      tick();
      check("idle_ack_done", done, 0);
      check("idle_ack_rdata", rdata_out, exp_rdata);

`ifdef MAU_TIMEOUT_EN
      MemRW = 1'b0; DataRSel = 3'd0; addr = 32'h0000_5000;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < TO_CYC; i++) begin
         check("to_req_high", bus.mem_req, 1);
         tick();
      end
      check("to_req_drop", bus.mem_req, 0);
      check("to_nodone", done, 0);
      tick();
      check("to_done", done, 1);
      check("to_err", err_timeout, 1);
      check("to_noalign", err_align, 0);
      check("to_rdata_keep", rdata_out, exp_rdata);
      tick();
      check("to_busy_low", busy, 0);
`endif

      // Randomized transactions.
      for (int t = 0; t < 40; t++) begin
         bit          we;
         bit [1:0]    ws;
         bit [2:0]    rs;
         logic [31:0] a;
         we = $urandom_range(0, 1);
         ws = 2'($urandom_range(0, 3));
         rs = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'($urandom_range(0, 1) * 2);
         do_txn(we, ws, rs, a, $urandom, $urandom, $urandom_range(0, 3),
                1'($urandom_range(0, 1)));
      end

      // Reset in the middle of REQ.
      MemRW = 1'b0; DataRSel = 3'd0; addr = 32'h0000_0040;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("pre_rst_req", bus.mem_req, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_req", bus.mem_req, 0);
      check("rst_mid_busy", busy, 0);
      tick();
      rst_n = 1'b1;
      exp_rdata = 32'h0;
      tick();
      check("post_rst_req", bus.mem_req, 0);
      check("post_rst_rdata", rdata_out, 0);
      do_txn(1'b0, 2'b00, 3'd0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
      check("post_rst_load", rdata_out, 32'hCAFE_F00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
